atan2_seq_ctrl: RTL and testbench

ATAN2_SEQ_CTRL -- requirements
Module: atan2_seq_ctrl

---
 rtl/atan2_pkg.sv | 32 +++
 rtl/atan2_multiplier.sv | 49 ++++
 rtl/atan2_seq_ctrl.sv | 115 +++++++++++
 tb/tb_atan2_seq_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/atan2_pkg.sv
// Shared constants, FSM state encoding and the 25-entry tangent-bin table for atan2_seq_ctrl.
package atan2_pkg;

    localparam int BIT_WIDTH        = 12;
    localparam int NO_FIRSTBITS_MUL = 9;
    localparam int NUM_BINS         = 25;
    localparam int CONST_W          = 11;
    localparam int K_W              = 5;
    localparam int SPLIT_BIT        = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL1,
        ST_MUL2,
        ST_CMP,
        ST_DONE
    } state_e;

    // Bin boundaries scaled by 2^NO_FIRSTBITS_MUL; products are compared against |y| << NO_FIRSTBITS_MUL.
    localparam logic [CONST_W-1:0] ATAN_TBL [NUM_BINS] = '{
        11'd2,   11'd6,   11'd10,  11'd14,  11'd18,
        11'd23,  11'd27,  11'd32,  11'd37,  11'd43,
        11'd49,  11'd56,  11'd63,  11'd72,  11'd82,
        11'd94,  11'd108, 11'd125, 11'd147, 11'd177,
        11'd220, 11'd286, 11'd404, 11'd676, 11'd2036
    };

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/atan2_multiplier.sv
// Two-stage shift-add multiplier of |x| by all 25 table constants at once.
module Atan2_Multiplier #(
    parameter int BIT_WIDTH = atan2_pkg::BIT_WIDTH,
    parameter int PW        = BIT_WIDTH + atan2_pkg::CONST_W
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     ena_i,
    input  logic [BIT_WIDTH-1:0]                     x_i,
    output logic [atan2_pkg::NUM_BINS-1:0][PW-1:0]   prod_o
);
    import atan2_pkg::*;

    logic [PW-1:0]                 xe;
    logic [NUM_BINS-1:0][PW-1:0]   lo_d, hi_d;
    logic [NUM_BINS-1:0][PW-1:0]   lo_q, hi_q;
    logic [NUM_BINS-1:0][PW-1:0]   prod_q;

    assign xe = PW'(x_i);

    // Stage 1 splits each constant into low/high bit groups so stage 2 only adds two terms.
    always_comb begin
        lo_d = '0;
        hi_d = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            for (int b = 0; b < CONST_W; b++) begin
                if (ATAN_TBL[i][b]) begin
                    if (b < SPLIT_BIT) lo_d[i] = lo_d[i] + (xe << b);
                    else               hi_d[i] = hi_d[i] + (xe << b);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lo_q   <= '0;
            hi_q   <= '0;
            prod_q <= '0;
        end else if (ena_i) begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            for (int i = 0; i < NUM_BINS; i++) prod_q[i] <= lo_q[i] + hi_q[i];
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/atan2_seq_ctrl.sv
// Sequencer for the atan2 bin search: accept moments, run the 2-stage multiplier, count bins.
// Optional completed-conversion counter enabled by defining ATAN2_CTRL_PERF_EN.
module atan2_seq_ctrl #(
    parameter int BIT_WIDTH        = atan2_pkg::BIT_WIDTH,
    parameter int NO_FIRSTBITS_MUL = atan2_pkg::NO_FIRSTBITS_MUL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_x,
    input  logic [BIT_WIDTH-1:0] in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_quad,
    output logic [4:0]           out_k,
    output logic [15:0]          perf_cnt
);
    import atan2_pkg::*;

    localparam int PW = BIT_WIDTH + CONST_W;
    localparam int YW = BIT_WIDTH + NO_FIRSTBITS_MUL;
    localparam int CW = max_i(PW, YW);

    state_e                      state_q, state_d;
    logic [BIT_WIDTH-1:0]        xa_q, ya_q;
    logic                        xn_q, yn_q;
    logic [K_W-1:0]              k_q, k_d;
    logic [BIT_WIDTH-1:0]        x_abs, y_abs;
    logic [YW-1:0]               ys;
    logic                        mul_ena;
    logic                        accept;
    logic [NUM_BINS-1:0][PW-1:0] prod;

    // Two's-complement magnitude; the most negative code maps onto its unsigned magnitude.
    assign x_abs = in_x[BIT_WIDTH-1] ? ((~in_x) + BIT_WIDTH'(1)) : in_x;
    assign y_abs = in_y[BIT_WIDTH-1] ? ((~in_y) + BIT_WIDTH'(1)) : in_y;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign mul_ena   = (state_q == ST_MUL1) || (state_q == ST_MUL2);

    Atan2_Multiplier #(
        .BIT_WIDTH (BIT_WIDTH),
        .PW        (PW)
    ) u_mul (
        .clk_i  (clk),
        .rst_i  (rst),
        .ena_i  (mul_ena),
        .x_i    (xa_q),
        .prod_o (prod)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_MUL1;
            ST_MUL1:                state_d = ST_MUL2;
            ST_MUL2:                state_d = ST_CMP;
            ST_CMP:                 state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    assign ys = YW'(ya_q) << NO_FIRSTBITS_MUL;

    always_comb begin
        k_d = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (CW'(prod[i]) < CW'(ys)) k_d = k_d + K_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            xa_q    <= '0;
            ya_q    <= '0;
            xn_q    <= 1'b0;
            yn_q    <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                xa_q <= x_abs;
                ya_q <= y_abs;
                xn_q <= in_x[BIT_WIDTH-1];
                yn_q <= in_y[BIT_WIDTH-1];
            end
            if (state_q == ST_CMP) k_q <= k_d;
        end
    end

    assign out_quad = {yn_q, xn_q};
    assign out_k    = k_q;

`ifdef ATAN2_CTRL_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == ST_DONE) && out_ready && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cnt = perf_q;
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_atan2_seq_ctrl.sv
// Randomized and directed bench for atan2_seq_ctrl against an arithmetic bin-count model.
module tb_atan2_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_x, in_y;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_quad;
    logic [4:0]  out_k;
    logic [15:0] perf_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_perf = 0;

    int tbl [25] = '{2, 6, 10, 14, 18, 23, 27, 32, 37, 43, 49, 56, 63, 72, 82,
                     94, 108, 125, 147, 177, 220, 286, 404, 676, 2036};

    atan2_seq_ctrl #(.BIT_WIDTH(12), .NO_FIRSTBITS_MUL(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quad  (out_quad),
        .out_k     (out_k),
        .perf_cnt  (perf_cnt)
    );

    always #5 clk = ~clk;

    // Number of bins whose boundary |x|*c still lies strictly below |y|*2^9.
    function automatic int ref_k(input int x, input int y);
        longint ax = (x < 0) ? -x : x;
        longint ay = (y < 0) ? -y : y;
        int n = 0;
        for (int i = 0; i < 25; i++) if (ax * tbl[i] < ay * 512) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic bump_perf();
`ifdef ATAN2_CTRL_PERF_EN
        if (exp_perf < 65535) exp_perf++;
`endif
    endtask

    task automatic convert(input int x, input int y, input int hold);
        int          lat;
        logic [4:0]  k0;
        logic [1:0]  q0;
        logic [11:0] xv, yv;
        xv = x[11:0];
        yv = y[11:0];
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 1);
        in_x      = xv;
        in_y      = yv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 4);
        chk("out_k", 32'(out_k), 32'(ref_k(x, y)));
        chk("out_quad", 32'(out_quad), 32'({y < 0, x < 0}));
        if (hold > 0) begin
            out_ready = 1'b0;
            k0 = out_k;
            q0 = out_quad;
            in_valid = 1'b1;
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                chk("hold_vld", 32'(out_valid), 1);
                chk("hold_k", 32'(out_k), 32'(k0));
                chk("hold_quad", 32'(out_quad), 32'(q0));
                chk("hold_rdy", 32'(in_ready), 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        bump_perf();
        chk("post_rdy", 32'(in_ready), 1);
        chk("post_vld", 32'(out_valid), 0);
        chk("perf", 32'(perf_cnt), 32'(exp_perf));
    endtask

    initial begin
        int x, y, exp3;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_k", 32'(out_k), 0);
        chk("rst_quad", 32'(out_quad), 0);
        chk("rst_perf", 32'(perf_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 1);

        convert(100, 0, 0);
        convert(1, 1, 0);
        convert(-3, -1, 0);
        convert(0, 5, 0);
        convert(-2048, 0, 0);
        convert(0, 0, 0);
        convert(7, -9, 10);

        // Abort a conversion while it sits in MUL2.
        @(negedge clk);
        in_x     = 12'd50;
        in_y     = 12'd60;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_perf = 0;
        chk("abort_vld", 32'(out_valid), 0);
        chk("abort_rdy", 32'(in_ready), 1);
        chk("abort_k", 32'(out_k), 0);
        chk("abort_quad", 32'(out_quad), 0);
        chk("abort_perf", 32'(perf_cnt), 0);
        convert(5, 3, 0);
        convert(-11, 40, 2);
        convert(2047, -2048, 0);
`ifdef ATAN2_CTRL_PERF_EN
        exp3 = 3;
`else
        exp3 = 0;
`endif
        chk("perf3", 32'(perf_cnt), 32'(exp3));

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                x = int'($urandom_range(0, 40)) - 20;
                y = int'($urandom_range(0, 40)) - 20;
            end else begin
                x = int'($urandom_range(0, 4095)) - 2048;
                y = int'($urandom_range(0, 4095)) - 2048;
            end
            convert(x, y, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
